// File: rtl/riscv_rf_mp_if.sv
// Bus bundle for the multi-port RISC-V register file: read/write ports,
// pipeline stalls, debug access and init status.
interface riscv_rf_mp_if #(
   parameter int XLEN     = 32,
   parameter int RD_PORTS = 2,
   parameter int WR_PORTS = 1
);
   logic [RD_PORTS*5-1:0]    rf_src_i;
   logic [RD_PORTS*XLEN-1:0] rf_src_q_o;
   logic [WR_PORTS*5-1:0]    rf_dst_i;
   logic [WR_PORTS*XLEN-1:0] rf_dst_d_i;
   logic [WR_PORTS-1:0]      rf_we_i;
   logic                     pd_stall_i;
   logic                     id_stall_i;
   logic                     du_re_rf_i;
   logic                     du_we_rf_i;
   logic [11:0]              du_addr_i;
   logic [XLEN-1:0]          du_d_i;
   logic [XLEN-1:0]          du_rf_q_o;
   logic                     du_rf_valid_o;
   logic                     rf_init_busy_o;

   modport master (
      output rf_src_i, rf_dst_i, rf_dst_d_i, rf_we_i, pd_stall_i, id_stall_i,
             du_re_rf_i, du_we_rf_i, du_addr_i, du_d_i,
      input  rf_src_q_o, du_rf_q_o, du_rf_valid_o, rf_init_busy_o
   );

   modport slave (
      input  rf_src_i, rf_dst_i, rf_dst_d_i, rf_we_i, pd_stall_i, id_stall_i,
             du_re_rf_i, du_we_rf_i, du_addr_i, du_d_i,
      output rf_src_q_o, du_rf_q_o, du_rf_valid_o, rf_init_busy_o
   );
endinterface

// File: rtl/riscv_rf_mp.sv
// Multi-port RISC-V integer register file with write forwarding, debug port
// and a post-reset sequence that zeroes every register before use.
module riscv_rf_mp #(
   parameter int XLEN     = 32,
   parameter int REGS     = 32,
   parameter int RD_PORTS = 2,
   parameter int WR_PORTS = 1,
   parameter int REGOUT   = 0,
   parameter int BYPASS   = 1
) (
   input logic          clk_i,
   input logic          rst_ni,
   riscv_rf_mp_if.slave rf
);
   localparam int AW = $clog2(REGS);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t          state_reg;
   logic [4:0]      clr_cnt_reg;
   logic            busy_reg;
   logic            run;
   logic [XLEN-1:0] mem_reg [REGS];

   logic            du_we_ok;
   logic            du_pend_reg;
   logic            du_valid_reg;
   logic [XLEN-1:0] du_q_reg;
   logic            unused_bits;

   logic [WR_PORTS-1:0] wr_ok;
   logic [4:0]          wr_addr [WR_PORTS];
   logic [XLEN-1:0]     wr_data [WR_PORTS];

   function automatic logic addr_ok(input logic [4:0] a);
      return (a != 5'd0) && (32'(a) < 32'(REGS));
   endfunction

   assign run         = (state_reg == ST_RUN);
   assign du_we_ok    = run && rf.du_we_rf_i && addr_ok(rf.du_addr_i[4:0]);
   assign unused_bits = ^{rf.du_addr_i[11:5], rf.id_stall_i};

   // A debug write blocks every write port, so their data must not forward either.
   generate
      for (genvar gi = 0; gi < WR_PORTS; gi++) begin : g_wr
         assign wr_addr[gi] = rf.rf_dst_i[gi*5 +: 5];
         assign wr_data[gi] = rf.rf_dst_d_i[gi*XLEN +: XLEN];
         assign wr_ok[gi]   = run && !rf.du_we_rf_i && rf.rf_we_i[gi] && addr_ok(wr_addr[gi]);
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= ST_INIT;
         clr_cnt_reg <= 5'd1;
         busy_reg    <= 1'b1;
      end else begin
         case (state_reg)
            ST_INIT: begin
               if (clr_cnt_reg == 5'(REGS - 1)) begin
                  state_reg <= ST_RUN;
                  busy_reg  <= 1'b0;
               end else begin
                  clr_cnt_reg <= clr_cnt_reg + 5'd1;
               end
            end
            default: begin
               state_reg <= ST_RUN;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Ascending port order makes the highest-index port win on collisions.
   always_ff @(posedge clk_i) begin
      if (!run) begin
         mem_reg[clr_cnt_reg[AW-1:0]] <= '0;
      end else if (du_we_ok) begin
         mem_reg[rf.du_addr_i[AW-1:0]] <= rf.du_d_i;
      end else begin
         for (int w = 0; w < WR_PORTS; w++) begin
            if (wr_ok[w]) mem_reg[wr_addr[w][AW-1:0]] <= wr_data[w];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
         logic [4:0]      addr_reg;
         logic [XLEN-1:0] rd_val;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               addr_reg <= 5'd0;
            end else if ((gi == 0) && run && rf.du_re_rf_i) begin
               addr_reg <= rf.du_addr_i[4:0];
            end else if (!rf.pd_stall_i) begin
               addr_reg <= rf.rf_src_i[gi*5 +: 5];
            end
         end

         always_comb begin
            rd_val = '0;
            if (addr_ok(addr_reg)) begin
               rd_val = mem_reg[addr_reg[AW-1:0]];
               if (BYPASS > 0) begin
                  for (int w = 0; w < WR_PORTS; w++) begin
                     if (wr_ok[w] && (wr_addr[w] == addr_reg)) rd_val = wr_data[w];
                  end
                  if (du_we_ok && (rf.du_addr_i[4:0] == addr_reg)) rd_val = rf.du_d_i;
               end
            end
         end

         if (REGOUT > 0) begin : g_regout
            logic [XLEN-1:0] out_reg;
            always_ff @(posedge clk_i or negedge rst_ni) begin
               if (!rst_ni) begin
                  out_reg <= '0;
               end else if (!rf.id_stall_i) begin
                  out_reg <= run ? rd_val : '0;
               end
            end
            assign rf.rf_src_q_o[gi*XLEN +: XLEN] = run ? out_reg : '0;
         end else begin : g_comb
            assign rf.rf_src_q_o[gi*XLEN +: XLEN] = run ? rd_val : '0;
         end
      end
   endgenerate

   // Debug read: address captured into port 0 first, data sampled one cycle later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         du_pend_reg  <= 1'b0;
         du_valid_reg <= 1'b0;
         du_q_reg     <= '0;
      end else begin
         du_pend_reg  <= run && rf.du_re_rf_i;
         du_valid_reg <= du_pend_reg;
         if (du_pend_reg) du_q_reg <= g_rd[0].rd_val;
      end
   end

   assign rf.du_rf_q_o      = du_q_reg;
   assign rf.du_rf_valid_o  = du_valid_reg;
   assign rf.rf_init_busy_o = busy_reg;
endmodule

// File: tb/tb_riscv_rf_mp.sv
// Directed bench: dut_a (REGS=32, 2 write ports, forwarding) and dut_b
// (REGS=16, 1 write port, no forwarding) driven from one linear sequence.
module tb_riscv_rf_mp;
   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;
   int   cnt_a, cnt_b;
   bit   bad_a;

   always #5 clk_i = ~clk_i;

   riscv_rf_mp_if #(.XLEN(32), .RD_PORTS(2), .WR_PORTS(2)) ia ();
   riscv_rf_mp_if #(.XLEN(32), .RD_PORTS(2), .WR_PORTS(1)) ib ();

   riscv_rf_mp #(.XLEN(32), .REGS(32), .RD_PORTS(2), .WR_PORTS(2), .REGOUT(0), .BYPASS(1))
      dut_a (.clk_i(clk_i), .rst_ni(rst_ni), .rf(ia));
   riscv_rf_mp #(.XLEN(32), .REGS(16), .RD_PORTS(2), .WR_PORTS(1), .REGOUT(0), .BYPASS(0))
      dut_b (.clk_i(clk_i), .rst_ni(rst_ni), .rf(ib));

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic idle();
      ia.rf_src_i = '0; ia.rf_dst_i = '0; ia.rf_dst_d_i = '0; ia.rf_we_i = '0;
      ia.pd_stall_i = 1'b0; ia.id_stall_i = 1'b0; ia.du_re_rf_i = 1'b0;
      ia.du_we_rf_i = 1'b0; ia.du_addr_i = '0; ia.du_d_i = '0;
      ib.rf_src_i = '0; ib.rf_dst_i = '0; ib.rf_dst_d_i = '0; ib.rf_we_i = '0;
      ib.pd_stall_i = 1'b0; ib.id_stall_i = 1'b0; ib.du_re_rf_i = 1'b0;
      ib.du_we_rf_i = 1'b0; ib.du_addr_i = '0; ib.du_d_i = '0;
   endtask

   // Counts busy cycles after release, bounded; flags dut_a activity seen during INIT.
   task automatic count_init(output int ca, output int cb, output bit bad);
      ca = 0; cb = 0; bad = 1'b0;
      for (int c = 0; c < 100; c++) begin
         #2;
         if (ia.rf_init_busy_o) begin
            ca++;
            if (ia.rf_src_q_o != '0 || ia.du_rf_valid_o) bad = 1'b1;
         end
         if (ib.rf_init_busy_o) cb++;
         if (!ia.rf_init_busy_o && !ib.rf_init_busy_o) break;
         cyc();
      end
   endtask

   initial begin
      idle();
      rst_ni = 1'b0;
      cyc(); cyc(); #2;
      $display("txn: reset held");
      chk("rst_busy_a", 32'(ia.rf_init_busy_o), 32'd1);
      chk("rst_busy_b", 32'(ib.rf_init_busy_o), 32'd1);
      chk("rst_valid_a", 32'(ia.du_rf_valid_o), 32'd0);
      chk("rst_duq_a", ia.du_rf_q_o, 32'd0);
      chk("rst_q0_a", ia.rf_src_q_o[31:0], 32'd0);

      cyc();
      rst_ni = 1'b1;
      count_init(cnt_a, cnt_b, bad_a);
      $display("txn: init busy a=%0d b=%0d", cnt_a, cnt_b);
      chk("init_len_a", 32'(cnt_a), 32'd31);
      chk("init_len_b", 32'(cnt_b), 32'd15);

      for (int i = 0; i < 32; i++) begin
         ia.rf_src_i = {5'(31 - i), 5'(i)};
         ib.rf_src_i = {5'(31 - i), 5'(i)};
         cyc(); #2;
         chk($sformatf("zero_a_p0_x%0d", i), ia.rf_src_q_o[31:0], 32'd0);
         chk($sformatf("zero_a_p1_x%0d", 31 - i), ia.rf_src_q_o[63:32], 32'd0);
         chk($sformatf("zero_b_p0_x%0d", i), ib.rf_src_q_o[31:0], 32'd0);
         chk($sformatf("zero_b_p1_x%0d", 31 - i), ib.rf_src_q_o[63:32], 32'd0);
      end
      $display("txn: post-init readback of all registers");

      // Forwarding: write x5 on port 0 while port 1 reads x5
      ia.rf_src_i = {5'd5, 5'd0};
      ib.rf_src_i = {5'd5, 5'd0};
      cyc();
      ia.rf_we_i = 2'b01; ia.rf_dst_i = {5'd0, 5'd5}; ia.rf_dst_d_i = {32'd0, 32'hDEADBEEF};
      ib.rf_we_i = 1'b1;  ib.rf_dst_i = 5'd5;         ib.rf_dst_d_i = 32'hDEADBEEF;
      #2;
      $display("txn: write x5=deadbeef with same-cycle read");
      chk("byp_on_a_p1", ia.rf_src_q_o[63:32], 32'hDEADBEEF);
      chk("byp_off_b_p1", ib.rf_src_q_o[63:32], 32'd0);
      cyc();
      ia.rf_we_i = '0; ib.rf_we_i = '0;
      #2;
      chk("x5_after_a", ia.rf_src_q_o[63:32], 32'hDEADBEEF);
      chk("x5_after_b", ib.rf_src_q_o[63:32], 32'hDEADBEEF);

      // Write priority on x7: debug beats both ports, then port 1 beats port 0
      ia.rf_src_i = {5'd0, 5'd7};
      cyc();
      ia.rf_we_i = 2'b11; ia.rf_dst_i = {5'd7, 5'd7}; ia.rf_dst_d_i = {32'h22, 32'h11};
      ia.du_we_rf_i = 1'b1; ia.du_addr_i = 12'd7; ia.du_d_i = 32'h33;
      #2;
      $display("txn: x7 written by both ports and debug");
      chk("prio_du_byp", ia.rf_src_q_o[31:0], 32'h33);
      cyc();
      ia.rf_we_i = '0; ia.du_we_rf_i = 1'b0;
      #2;
      chk("prio_du_mem", ia.rf_src_q_o[31:0], 32'h33);
      cyc();
      ia.rf_we_i = 2'b11;
      #2;
      $display("txn: x7 written by both ports");
      chk("prio_p1_byp", ia.rf_src_q_o[31:0], 32'h22);
      cyc();
      ia.rf_we_i = '0;
      #2;
      chk("prio_p1_mem", ia.rf_src_q_o[31:0], 32'h22);

      // Out-of-range and x0 accesses
      ia.rf_src_i = {5'd0, 5'd20}; ia.rf_we_i = 2'b11;
      ia.rf_dst_i = {5'd0, 5'd20}; ia.rf_dst_d_i = {32'h99, 32'h55};
      ib.rf_src_i = {5'd0, 5'd20}; ib.rf_we_i = 1'b1;
      ib.rf_dst_i = 5'd20;         ib.rf_dst_d_i = 32'h55;
      cyc();
      ia.rf_we_i = '0; ib.rf_we_i = '0;
      #2;
      $display("txn: write x20=55, read x20 and x0");
      chk("x20_a_stored", ia.rf_src_q_o[31:0], 32'h55);
      chk("x0_a_zero", ia.rf_src_q_o[63:32], 32'd0);
      chk("x20_b_zero", ib.rf_src_q_o[31:0], 32'd0);
      chk("x0_b_zero", ib.rf_src_q_o[63:32], 32'd0);

      // Debug read of x3 under pipeline stall
      cyc();
      ia.rf_we_i = 2'b01; ia.rf_dst_i = {5'd0, 5'd3}; ia.rf_dst_d_i = {32'd0, 32'h1234};
      ib.rf_we_i = 1'b1;  ib.rf_dst_i = 5'd3;         ib.rf_dst_d_i = 32'h1234;
      cyc();
      ia.rf_we_i = '0; ib.rf_we_i = '0;
      cyc();
      ia.pd_stall_i = 1'b1; ia.du_re_rf_i = 1'b1; ia.du_addr_i = 12'd3; ia.rf_src_i = {5'd9, 5'd9};
      ib.pd_stall_i = 1'b1; ib.du_re_rf_i = 1'b1; ib.du_addr_i = 12'd3; ib.rf_src_i = {5'd9, 5'd9};
      #2;
      $display("txn: debug read x3 with pd_stall");
      chk("dbg_n_valid_a", 32'(ia.du_rf_valid_o), 32'd0);
      cyc();
      ia.du_re_rf_i = 1'b0; ib.du_re_rf_i = 1'b0;
      #2;
      chk("dbg_n1_valid_a", 32'(ia.du_rf_valid_o), 32'd0);
      chk("dbg_n1_valid_b", 32'(ib.du_rf_valid_o), 32'd0);
      chk("dbg_n1_q_a", ia.du_rf_q_o, 32'd0);
      chk("dbg_n1_p0_a", ia.rf_src_q_o[31:0], 32'h1234);
      cyc(); #2;
      chk("dbg_n2_valid_a", 32'(ia.du_rf_valid_o), 32'd1);
      chk("dbg_n2_q_a", ia.du_rf_q_o, 32'h1234);
      chk("dbg_n2_valid_b", 32'(ib.du_rf_valid_o), 32'd1);
      chk("dbg_n2_q_b", ib.du_rf_q_o, 32'h1234);
      cyc(); #2;
      chk("dbg_n3_valid_a", 32'(ia.du_rf_valid_o), 32'd0);
      chk("dbg_n3_hold_a", ia.du_rf_q_o, 32'h1234);

      // Back-to-back debug reads of x5 then x7
      cyc();
      ia.du_re_rf_i = 1'b1; ia.du_addr_i = 12'd5;
      cyc();
      ia.du_addr_i = 12'd7;
      cyc();
      ia.du_re_rf_i = 1'b0;
      #2;
      $display("txn: back-to-back debug reads x5, x7");
      chk("b2b_1_valid", 32'(ia.du_rf_valid_o), 32'd1);
      chk("b2b_1_q", ia.du_rf_q_o, 32'hDEADBEEF);
      cyc(); #2;
      chk("b2b_2_valid", 32'(ia.du_rf_valid_o), 32'd1);
      chk("b2b_2_q", ia.du_rf_q_o, 32'h22);
      cyc(); #2;
      chk("b2b_end_valid", 32'(ia.du_rf_valid_o), 32'd0);

      // Reset aborts a pending debug read
      cyc();
      ia.pd_stall_i = 1'b0; ib.pd_stall_i = 1'b0;
      ia.du_re_rf_i = 1'b1; ia.du_addr_i = 12'd3;
      cyc();
      ia.du_re_rf_i = 1'b0;
      rst_ni = 1'b0;
      #2;
      $display("txn: reset during debug read");
      chk("abort_valid", 32'(ia.du_rf_valid_o), 32'd0);
      chk("abort_q", ia.du_rf_q_o, 32'd0);
      chk("abort_busy_a", 32'(ia.rf_init_busy_o), 32'd1);
      cyc(); #2;
      chk("abort_no_strobe", 32'(ia.du_rf_valid_o), 32'd0);

      // Release, then pulse reset at INIT cycle 10 with ignored traffic on dut_a
      cyc();
      rst_ni = 1'b1;
      ia.rf_we_i = 2'b01; ia.rf_dst_i = {5'd0, 5'd5}; ia.rf_dst_d_i = {32'd0, 32'hFF};
      ia.rf_src_i = {5'd5, 5'd5}; ib.rf_src_i = {5'd5, 5'd5};
      ia.du_re_rf_i = 1'b1; ia.du_addr_i = 12'd5;
      bad_a = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #2;
         if (ia.rf_src_q_o != '0 || ia.du_rf_valid_o) bad_a = 1'b1;
         cyc();
      end
      chk("init_early_quiet", 32'(bad_a), 32'd0);
      rst_ni = 1'b0;
      #2;
      $display("txn: reset pulse at init cycle 10");
      chk("pulse_busy_a", 32'(ia.rf_init_busy_o), 32'd1);
      cyc();
      rst_ni = 1'b1;
      count_init(cnt_a, cnt_b, bad_a);
      ia.rf_we_i = '0; ia.du_re_rf_i = 1'b0;
      $display("txn: re-init busy a=%0d b=%0d", cnt_a, cnt_b);
      chk("reinit_len_a", 32'(cnt_a), 32'd31);
      chk("reinit_len_b", 32'(cnt_b), 32'd15);
      chk("init_quiet_a", 32'(bad_a), 32'd0);
      cyc(); #2;
      chk("reinit_x5_a_p0", ia.rf_src_q_o[31:0], 32'd0);
      chk("reinit_x5_a_p1", ia.rf_src_q_o[63:32], 32'd0);
      chk("reinit_x5_b_p0", ib.rf_src_q_o[31:0], 32'd0);
      chk("reinit_duq_a", ia.du_rf_q_o, 32'd0);
      chk("reinit_valid_a", 32'(ia.du_rf_valid_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
